// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache refills/writebacks.
// D-cache has priority; a starve counter forces an I-cache win after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic                  ic_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_gnt,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_done,
  output logic                  dc_wready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int OFF_W = $clog2(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic ic_win_s, dc_win_s, beat_ok_s, rd_fwd_s, wr_act_s, starved_s;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    line_align = a & LINE_MASK;
  endfunction

  assign starved_s = (starve_q == STV_MAX);
  assign ic_win_s  = (state_q == S_IDLE) && ic_req && (!dc_req || starved_s);
  assign dc_win_s  = (state_q == S_IDLE) && dc_req && !(ic_req && starved_s);
  assign rd_fwd_s  = (state_q == S_DATA) && !we_q;
  assign wr_act_s  = (state_q == S_DATA) && we_q;
  // A beat counts only on the handshake that matches the burst direction.
  assign beat_ok_s = we_q ? (wr_act_s && mem_wready) : (rd_fwd_s && mem_rvalid);

  // Next-state, ownership latch, beat and starvation counters.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (ic_win_s) begin
          owner_d  = OWN_IC;
          we_d     = 1'b0;
          addr_d   = line_align(ic_addr);
          starve_d = '0;
          state_d  = S_CMD;
        end else if (dc_win_s) begin
          owner_d  = OWN_DC;
          we_d     = dc_we;
          addr_d   = line_align(dc_addr);
          starve_d = (ic_req && !starved_s) ? starve_q + STV_W'(1) : starve_q;
          state_d  = S_CMD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CMD: begin
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        if (beat_ok_s) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IC;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign ic_gnt     = ic_win_s;
  assign dc_gnt     = dc_win_s;
  assign ic_rvalid  = rd_fwd_s && (owner_q == OWN_IC) && mem_rvalid;
  assign dc_rvalid  = rd_fwd_s && (owner_q == OWN_DC) && mem_rvalid;
  assign ic_rdata   = (rd_fwd_s && (owner_q == OWN_IC)) ? mem_rdata : '0;
  assign dc_rdata   = (rd_fwd_s && (owner_q == OWN_DC)) ? mem_rdata : '0;
  assign ic_done    = (state_q == S_DONE) && (owner_q == OWN_IC);
  assign dc_done    = (state_q == S_DONE) && (owner_q == OWN_DC);
  assign mem_req    = (state_q == S_CMD);
  assign mem_we     = (state_q == S_CMD) && we_q;
  assign mem_addr   = (state_q == S_CMD) ? addr_q : '0;
  assign mem_wvalid = wr_act_s;
  assign mem_wdata  = wr_act_s ? dc_wdata : '0;
  assign dc_wready  = wr_act_s && mem_wready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with BURST_LEN=4, STARVE_LIMIT=2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we, mem_ack, mem_rvalid, mem_wready;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, dc_wready;
  logic        mem_req, mem_we, mem_wvalid;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4), .STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .dc_wready(dc_wready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
    .mem_wdata(mem_wdata), .mem_wready(mem_wready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one read burst from the IDLE cycle in which the winner is requesting.
  task automatic read_burst(input string tag, input bit exp_ic, input logic [31:0] exp_addr,
                            input int ncmd, input bit drop_req, input bit raise_dc);
    logic [31:0] d;
    #1;
    chk({tag, ".ic_gnt"}, 64'(ic_gnt), 64'(exp_ic));
    chk({tag, ".dc_gnt"}, 64'(dc_gnt), 64'(!exp_ic));
    tick();
    for (int c = 0; c < ncmd; c++) begin
      mem_ack = (c == ncmd - 1);
      #1;
      chk({tag, ".mem_req"}, 64'(mem_req), 64'd1);
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(exp_addr));
      chk({tag, ".mem_we"}, 64'(mem_we), 64'd0);
      tick();
    end
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      d = 32'hC0DE_0000 | 32'(b) | (32'(exp_ic) << 8);
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      #1;
      chk({tag, ".owner_rvalid"}, 64'(exp_ic ? ic_rvalid : dc_rvalid), 64'd1);
      chk({tag, ".owner_rdata"}, 64'(exp_ic ? ic_rdata : dc_rdata), 64'(d));
      chk({tag, ".other_rvalid"}, 64'(exp_ic ? dc_rvalid : ic_rvalid), 64'd0);
      chk({tag, ".early_done"}, 64'(ic_done | dc_done), 64'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    if (raise_dc) begin
      dc_req  = 1'b1;
      dc_we   = 1'b0;
      dc_addr = 32'h0000_7004;
    end
    #1;
    chk({tag, ".owner_done"}, 64'(exp_ic ? ic_done : dc_done), 64'd1);
    chk({tag, ".other_done"}, 64'(exp_ic ? dc_done : ic_done), 64'd0);
    chk({tag, ".gnt_in_done"}, 64'(ic_gnt | dc_gnt), 64'd0);
    if (drop_req) begin
      if (exp_ic) ic_req = 1'b0;
      else        dc_req = 1'b0;
    end
    tick();
  endtask

  logic [31:0] wd [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
  bit          wr_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  bit          glitch [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int idx;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b0; mem_wready = 1'b0; ic_addr = '0; dc_addr = '0;
    dc_wdata = '0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.mem_addr", 64'(mem_addr), 64'd0);
    chk("reset.gnts", 64'({ic_gnt, dc_gnt}), 64'd0);
    chk("reset.dones", 64'({ic_done, dc_done}), 64'd0);
    chk("reset.wvalid", 64'(mem_wvalid), 64'd0);
    tick();

    // IC alone, immediate ack and beats.
    ic_req = 1'b1; ic_addr = 32'h0000_1234;
    read_burst("ic_alone", 1'b1, 32'h0000_1230, 1, 1'b1, 1'b0);
    #1;
    chk("ic_alone.idle_quiet", 64'({ic_gnt, ic_done, mem_req}), 64'd0);
    tick();

    // DC writeback with wready stalls and rvalid glitches.
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2008; dc_wdata = wd[0];
    #1;
    chk("dc_wb.gnt", 64'(dc_gnt), 64'd1);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("dc_wb.mem_we", 64'(mem_we), 64'd1);
    chk("dc_wb.mem_addr", 64'(mem_addr), 64'h2000);
    tick();
    mem_ack = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      mem_wready = wr_pat[i];
      mem_rvalid = glitch[i];
      #1;
      chk("dc_wb.wvalid", 64'(mem_wvalid), 64'd1);
      chk("dc_wb.wdata", 64'(mem_wdata), 64'(wd[idx]));
      chk("dc_wb.wready", 64'(dc_wready), 64'(wr_pat[i]));
      chk("dc_wb.rvalid_ignored", 64'({dc_rvalid, ic_rvalid}), 64'd0);
      chk("dc_wb.early_done", 64'(dc_done), 64'd0);
      tick();
      if (wr_pat[i]) idx++;
      if (idx < 4) dc_wdata = wd[idx];
    end
    mem_wready = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk("dc_wb.done", 64'(dc_done), 64'd1);
    chk("dc_wb.wvalid_off", 64'(mem_wvalid), 64'd0);
    dc_req = 1'b0; dc_we = 1'b0;
    tick();
    mem_rvalid = 1'b0;

    // Both requesting continuously: DC, DC, IC, DC, DC, IC.
    ic_req = 1'b1; ic_addr = 32'h0000_4044;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_301C;
    read_burst("starve1", 1'b0, 32'h0000_3010, 1, 1'b0, 1'b0);
    read_burst("starve2", 1'b0, 32'h0000_3010, 1, 1'b0, 1'b0);
    read_burst("starve3", 1'b1, 32'h0000_4040, 1, 1'b0, 1'b0);
    read_burst("starve4", 1'b0, 32'h0000_3010, 1, 1'b0, 1'b0);
    read_burst("starve5", 1'b0, 32'h0000_3010, 1, 1'b0, 1'b0);
    read_burst("starve6", 1'b1, 32'h0000_4040, 1, 1'b0, 1'b0);
    ic_req = 1'b0; dc_req = 1'b0;
    tick();

    // Delayed mem_ack: CMD held for 5 cycles.
    ic_req = 1'b1; ic_addr = 32'h0000_5678;
    read_burst("ack_delay", 1'b1, 32'h0000_5670, 5, 1'b1, 1'b0);
    tick();

    // Reset during beat 2 of an IC refill.
    ic_req = 1'b1; ic_addr = 32'h0000_6000;
    #1;
    chk("rst_mid.gnt", 64'(ic_gnt), 64'd1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0000;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ic_req = 1'b0;
    #1;
    chk("rst_mid.rvalid", 64'(ic_rvalid), 64'd0);
    chk("rst_mid.rdata", 64'(ic_rdata), 64'd0);
    chk("rst_mid.done", 64'(ic_done), 64'd0);
    chk("rst_mid.mem_req", 64'(mem_req), 64'd0);
    tick();
    #1;
    chk("rst_mid.no_late_done", 64'(ic_done), 64'd0);
    mem_rvalid = 1'b0;
    tick();
    ic_req = 1'b1; ic_addr = 32'h0000_6010;
    read_burst("rst_after", 1'b1, 32'h0000_6010, 1, 1'b1, 1'b0);
    tick();

    // ic_req held past done re-grants; dc_req raised in DONE waits for IDLE.
    ic_req = 1'b1; ic_addr = 32'h0000_8020;
    read_burst("hold1", 1'b1, 32'h0000_8020, 1, 1'b0, 1'b0);
    read_burst("hold2", 1'b1, 32'h0000_8020, 1, 1'b1, 1'b1);
    read_burst("late_dc", 1'b0, 32'h0000_7000, 1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
